// File: rtl/as1802_pkg.sv
// Shared constants for the AS1802 memory arbiter slice.
// Requester indices, default block limit and memory widths.
package as1802_pkg;
    localparam int REQ_HOST    = 0;
    localparam int REQ_DMA     = 1;
    localparam int BLK_LIM_DEF = 255;
    localparam int DW          = 8;
    localparam int AW          = 16;
endpackage

// File: rtl/as1802_rr_arb2.sv
// Two-way round-robin grant: a tie goes to the requester
// that was not granted last.
module as1802_rr_arb2
    import as1802_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        unique case (eligible)
            2'b11:   grant = last ? 2'b01 : 2'b10;
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/as1802_mem_arbiter.sv
// Shares one SRAM between the 1802 CPU (zero-wait priority)
// and two round-robin requesters that use idle cycles.
module as1802_mem_arbiter
    import as1802_pkg::*;
#(
    parameter int BLK_LIM = BLK_LIM_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    cpu_addr,
    input  logic          cpu_tpa,
    input  logic          cpu_mrd,
    input  logic          cpu_mwr,
    input  logic [DW-1:0] cpu_dout,
    output logic [DW-1:0] cpu_din,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_busy,
    output logic [7:0]    blk_cnt
);
    localparam logic [7:0] LIM = 8'(BLK_LIM);

    logic [7:0]    r_hi_q;
    logic          r_last_q;
    logic [1:0]    r_ack;
    logic [DW-1:0] r_p0_rdata;
    logic [DW-1:0] r_p1_rdata;
    logic [7:0]    r_blk_cnt;

    logic          w_busy;
    logic          w_we;
    logic [1:0]    w_elig;
    logic [1:0]    w_arb_elig;
    logic [1:0]    w_grant;

    assign w_busy = ~cpu_mrd | ~cpu_mwr | cpu_tpa;
    assign w_elig = {p1_req & ~r_ack[REQ_DMA],
                     p0_req & ~r_ack[REQ_HOST]};
    // No grant while held in reset, so nothing commits or acks.
    assign w_arb_elig = (rst_n & ~w_busy) ? w_elig : 2'b00;

    as1802_rr_arb2 u_rr (
        .eligible (w_arb_elig),
        .last     (r_last_q),
        .grant    (w_grant)
    );

    always_comb begin
        mem_addr  = {r_hi_q, cpu_addr};
        mem_wdata = cpu_dout;
        w_we      = 1'b0;
        unique case (1'b1)
            w_busy: begin
                w_we = ~cpu_mwr;
            end
            w_grant[REQ_HOST]: begin
                mem_addr  = p0_addr;
                mem_wdata = p0_wdata;
                w_we      = p0_we;
            end
            w_grant[REQ_DMA]: begin
                mem_addr  = p1_addr;
                mem_wdata = p1_wdata;
                w_we      = p1_we;
            end
            default: ;
        endcase
    end

    assign mem_we   = w_we & rst_n;
    assign cpu_din  = mem_rdata;
    assign cpu_busy = w_busy;
    assign p0_ack   = r_ack[REQ_HOST];
    assign p1_ack   = r_ack[REQ_DMA];
    assign p0_rdata = r_p0_rdata;
    assign p1_rdata = r_p1_rdata;
    assign blk_cnt  = r_blk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_q <= 8'h00;
        end else if (cpu_tpa) begin
            r_hi_q <= cpu_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_q   <= 1'b1;
            r_ack      <= 2'b00;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
            r_blk_cnt  <= 8'h00;
        end else begin
            r_ack <= w_grant;
            if (w_grant[REQ_HOST] && !p0_we) begin
                r_p0_rdata <= mem_rdata;
            end
            if (w_grant[REQ_DMA] && !p1_we) begin
                r_p1_rdata <= mem_rdata;
            end
            if (|w_grant) begin
                r_last_q  <= w_grant[REQ_DMA];
                r_blk_cnt <= 8'h00;
            end else if (w_busy && (|w_elig) && (r_blk_cnt < LIM)) begin
                r_blk_cnt <= r_blk_cnt + 8'h01;
            end
        end
    end
endmodule

// File: tb/tb_as1802_mem_arbiter.sv
// Directed bench for as1802_mem_arbiter with a behavioural SRAM.
// A second instance with BLK_LIM=3 shares stimulus for saturation.
module tb_as1802_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cpu_addr;
    logic        cpu_tpa, cpu_mrd, cpu_mwr;
    logic [7:0]  cpu_dout, cpu_din;
    logic        p0_req, p0_we, p0_ack;
    logic [15:0] p0_addr;
    logic [7:0]  p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_ack;
    logic [15:0] p1_addr;
    logic [7:0]  p1_wdata, p1_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we, cpu_busy;
    logic [7:0]  blk_cnt;

    logic [7:0]  d2_cpu_din, d2_p0_rdata, d2_p1_rdata;
    logic [7:0]  d2_mem_wdata, d2_blk_cnt;
    logic [15:0] d2_mem_addr;
    logic        d2_p0_ack, d2_p1_ack, d2_mem_we, d2_cpu_busy;

    logic [7:0]  mem [0:65535];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    as1802_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_tpa(cpu_tpa),
        .cpu_mrd(cpu_mrd), .cpu_mwr(cpu_mwr),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata),
        .cpu_busy(cpu_busy), .blk_cnt(blk_cnt)
    );

    as1802_mem_arbiter #(.BLK_LIM(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_tpa(cpu_tpa),
        .cpu_mrd(cpu_mrd), .cpu_mwr(cpu_mwr),
        .cpu_dout(cpu_dout), .cpu_din(d2_cpu_din),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(d2_p0_ack), .p0_rdata(d2_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(d2_p1_ack), .p1_rdata(d2_p1_rdata),
        .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata),
        .mem_we(d2_mem_we), .mem_rdata(8'h00),
        .cpu_busy(d2_cpu_busy), .blk_cnt(d2_blk_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] acks [4];
        bit         seen;
        acks = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1234] = 8'hA5;
        rst_n = 1'b0;
        cpu_addr = 8'h00; cpu_tpa = 1'b0;
        cpu_mrd = 1'b1; cpu_mwr = 1'b1; cpu_dout = 8'h00;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;

        #3;
        chk("rst_blk", blk_cnt, 8'h00);
        chk("rst_acks", {p1_ack, p0_ack}, 2'b00);
        chk("rst_rdata", {p1_rdata, p0_rdata}, 16'h0000);
        cpu_mwr = 1'b0;
        #1;
        chk("rst_we_gated", mem_we, 1'b0);
        cpu_mwr = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Long read with high-byte strobe.
        cpu_tpa = 1'b1; cpu_addr = 8'h12;
        tick();
        cpu_tpa = 1'b0; cpu_mrd = 1'b0; cpu_addr = 8'h34;
        #1;
        chk("lr_addr", mem_addr, 16'h1234);
        chk("lr_din", cpu_din, 8'hA5);
        chk("lr_busy", cpu_busy, 1'b1);
        tick();

        // Short write reusing the held high byte.
        cpu_mrd = 1'b1; cpu_mwr = 1'b0;
        cpu_addr = 8'h35; cpu_dout = 8'h5A;
        #1;
        chk("sw_addr", mem_addr, 16'h1235);
        chk("sw_we", mem_we, 1'b1);
        tick();
        cpu_mwr = 1'b1;
        #1;
        chk("sw_mem", mem[16'h1235], 8'h5A);
        chk("sw_noack", {p1_ack, p0_ack}, 2'b00);

        // Write together with tpa: old high byte used this cycle.
        cpu_tpa = 1'b1; cpu_mwr = 1'b0;
        cpu_addr = 8'h99; cpu_dout = 8'hC3;
        #1;
        chk("tw_addr", mem_addr, 16'h1299);
        tick();
        cpu_tpa = 1'b0; cpu_mwr = 1'b1; cpu_addr = 8'h00;
        #1;
        chk("tw_mem", mem[16'h1299], 8'hC3);
        chk("idle_addr", mem_addr, 16'h9900);
        chk("idle_we", mem_we, 1'b0);

        // DMA write blocked by a 5-cycle CPU read.
        cpu_mrd = 1'b0; cpu_addr = 8'h34;
        p1_req = 1'b1; p1_we = 1'b1;
        p1_addr = 16'h8000; p1_wdata = 8'h77;
        repeat (5) tick();
        cpu_mrd = 1'b1;
        #1;
        chk("blk5", blk_cnt, 8'h05);
        chk("p1_addr", mem_addr, 16'h8000);
        chk("p1_we", mem_we, 1'b1);
        tick();
        chk("p1_ack", p1_ack, 1'b1);
        chk("p1_mem", mem[16'h8000], 8'h77);
        chk("blk_clr", blk_cnt, 8'h00);
        p1_req = 1'b0;
        tick();
        chk("p1_ack_pulse", p1_ack, 1'b0);

        // Saturation and host read after the blocked window.
        cpu_mrd = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h1234;
        repeat (10) tick();
        chk("blk10", blk_cnt, 8'd10);
        chk("blk_sat3", d2_blk_cnt, 8'd3);
        cpu_mrd = 1'b1;
        tick();
        chk("p0_ack", p0_ack, 1'b1);
        chk("p0_rdata", p0_rdata, 8'hA5);
        p0_req = 1'b0;
        tick();

        // Reset during a host grant cycle.
        p0_req = 1'b1; p0_we = 1'b1;
        p0_addr = 16'h4000; p0_wdata = 8'hEE;
        cpu_addr = 8'h56;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_we", mem_we, 1'b0);
        chk("mr_hi", mem_addr, 16'h0056);
        @(posedge clk);
        #1;
        chk("mr_noack", p0_ack, 1'b0);
        chk("mr_nowr", mem[16'h4000], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            tick();
            if (p0_ack) seen = 1'b1;
        end
        chk("mr_regrant", seen, 1'b1);
        chk("mr_wr", mem[16'h4000], 8'hEE);
        p0_req = 1'b0; p0_we = 1'b0;
        tick();

        // Fresh reset, then both requesters contend.
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        chk("rr_rst_rdata", p0_rdata, 8'h00);
        p0_req = 1'b1; p0_addr = 16'h1234;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h1235;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr_ack%0d", i), {p1_ack, p0_ack}, acks[i]);
            if (i == 1) begin
                chk("rr_p0_rdata", p0_rdata, 8'hA5);
                chk("rr_p1_rdata", p1_rdata, 8'h5A);
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
